// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths and types for the registered priority encoder
package encoder_pkg;
  localparam int IN_W = 8;
  localparam int OUT_W = 3;
  typedef logic [IN_W-1:0] req_t;
  typedef logic [OUT_W-1:0] idx_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, bit 7 highest priority
module prio_enc8
  import encoder_pkg::*;
(
  input  req_t req,
  output idx_t idx,
  output logic any,
  output logic multi
);
  always_comb begin
    idx = req[7] ? 3'd7 :
          req[6] ? 3'd6 :
          req[5] ? 3'd5 :
          req[4] ? 3'd4 :
          req[3] ? 3'd3 :
          req[2] ? 3'd2 :
          req[1] ? 3'd1 : 3'd0;
    any = |req;
    // clearing the lowest set bit leaves something only if two or more were set
    multi = |(req & (req - req_t'(1)));
  end
endmodule

// File: rtl/encoder.sv
// encoder: registered 8-to-3 priority encoder with enable; ENCODER_MULTIHOT_ERR_EN adds err
module encoder
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             enable,
  output logic [OUT_W-1:0] y,
`ifdef ENCODER_MULTIHOT_ERR_EN
  output logic             err,
`endif
  output logic             valid
);
  idx_t idx;
  logic any;
  logic multi;
  prio_enc8 u_prio (
    .req  (in),
    .idx  (idx),
    .any  (any),
    .multi(multi)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
      valid <= 1'b0;
    end else begin
      y <= enable ? idx : '0;
      valid <= enable & any;
    end
  end
`ifdef ENCODER_MULTIHOT_ERR_EN
  always_ff @(posedge clk) err <= rst ? 1'b0 : enable & multi;
`else
  logic unused_multi;
  assign unused_multi = multi;
`endif
endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed-vector bench for encoder
module tb_encoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       enable;
  logic [2:0] y;
  logic       valid;
  int         n_assert = 0;
  int         n_fail = 0;
`ifdef ENCODER_MULTIHOT_ERR_EN
  logic       err;
`endif

  encoder dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .enable(enable),
    .y     (y),
`ifdef ENCODER_MULTIHOT_ERR_EN
    .err   (err),
`endif
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [7:0] i, input logic e,
                      input logic [2:0] ey, input logic ev, input logic ee);
    rst = r;
    in = i;
    enable = e;
    @(posedge clk);
    #1;
    check({tag, ".y"}, {5'd0, y}, {5'd0, ey});
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
`ifdef ENCODER_MULTIHOT_ERR_EN
    check({tag, ".err"}, {7'd0, err}, {7'd0, ee});
`else
    if (ee) begin end
`endif
  endtask

  initial begin
    rst = 1'b1;
    in = 8'hFF;
    enable = 1'b1;
    @(negedge clk);
    step("reset", 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0);
    step("oh01", 1'b0, 8'h01, 1'b1, 3'd0, 1'b1, 1'b0);
    step("oh02", 1'b0, 8'h02, 1'b1, 3'd1, 1'b1, 1'b0);
    step("oh80", 1'b0, 8'h80, 1'b1, 3'd7, 1'b1, 1'b0);
    step("midrst", 1'b1, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);
    step("oh10", 1'b0, 8'h10, 1'b1, 3'd4, 1'b1, 1'b0);
    step("oh08", 1'b0, 8'h08, 1'b1, 3'd3, 1'b1, 1'b0);
    step("oh04", 1'b0, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0);
    step("oh20", 1'b0, 8'h20, 1'b1, 3'd5, 1'b1, 1'b0);
    step("oh40", 1'b0, 8'h40, 1'b1, 3'd6, 1'b1, 1'b0);
    step("prio16", 1'b0, 8'b0001_0110, 1'b1, 3'd4, 1'b1, 1'b1);
    step("prioFF", 1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b1);
    step("prio03", 1'b0, 8'h03, 1'b1, 3'd1, 1'b1, 1'b1);
    step("zero", 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    step("dis80", 1'b0, 8'h80, 1'b0, 3'd0, 1'b0, 1'b0);
    step("disFF", 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    step("en80", 1'b0, 8'h80, 1'b1, 3'd7, 1'b1, 1'b0);
    step("dis_again", 1'b0, 8'h40, 1'b0, 3'd0, 1'b0, 1'b0);
    step("en40", 1'b0, 8'h40, 1'b1, 3'd6, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
